grid_scanner: RTL and testbench

GRID_SCANNER -- requirements
Module: grid_scanner

---
 rtl/grid_scanner.sv | 80 ++++++++
 tb/tb_grid_scanner.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/grid_scanner.sv
// grid_scanner: snapshots a cell grid on gen_tick and streams it bit-serially over a valid/ready link.
// Define GRID_SCANNER_POPCOUNT_EN to build the per-frame live-cell counter behind alive_count.
module grid_scanner #(
   parameter int ROWS = 8,
   parameter int COLS = 8,
   localparam int N = ROWS * COLS,
   localparam int CW = $clog2(N + 1)
) (
   input  logic          qzt_clk,
   input  logic          rst_n,
   input  logic          gen_tick,
   input  logic [N-1:0]  grid_state,
   input  logic          out_ready,
   input  logic          overrun_clr,
   output logic          out_valid,
   output logic          out_bit,
   output logic          out_sof,
   output logic          out_eol,
   output logic          frame_done,
   output logic          overrun,
   output logic [CW-1:0] alive_count
);
   localparam int IW = N > 1 ? $clog2(N) : 1;
   localparam int KW = COLS > 1 ? $clog2(COLS) : 1;
   localparam logic [IW-1:0] LAST = IW'(N - 1);
   localparam logic [KW-1:0] LAST_COL = KW'(COLS - 1);
   typedef enum logic {IDLE, SEND} state_t;
   state_t state, state_nxt;
   logic [N-1:0] shadow;
   logic [IW-1:0] idx;
   logic [KW-1:0] col;
   logic xfer, final_xfer, start;
   assign out_valid = state == SEND;
   assign xfer = out_valid & out_ready;
   assign final_xfer = xfer & (idx == LAST);
   // a tick coinciding with the final transfer chains straight into the next frame
   assign start = gen_tick & (state == IDLE | final_xfer);
   assign out_bit = out_valid & shadow[idx];
   assign out_sof = out_valid & (idx == '0);
   assign out_eol = out_valid & (col == LAST_COL);
   always_ff @(posedge qzt_clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nxt;
   always_comb begin
      state_nxt = start ? SEND : final_xfer ? IDLE : state;
   end
   always_ff @(posedge qzt_clk or negedge rst_n)
      if (!rst_n) begin
         shadow <= '0;
         idx <= '0;
         col <= '0;
         frame_done <= 1'b0;
         overrun <= 1'b0;
      end else begin
         frame_done <= final_xfer;
         overrun <= (gen_tick & out_valid & ~start) | (overrun & ~overrun_clr);
         if (start) begin
            shadow <= grid_state;
            idx <= '0;
            col <= '0;
         end else if (xfer) begin
            idx <= final_xfer ? '0 : idx + IW'(1);
            col <= col == LAST_COL ? '0 : col + KW'(1);
         end
      end
`ifdef GRID_SCANNER_POPCOUNT_EN
   logic [CW-1:0] cnt;
   always_ff @(posedge qzt_clk or negedge rst_n)
      if (!rst_n) begin
         cnt <= '0;
         alive_count <= '0;
      end else if (final_xfer) begin
         alive_count <= cnt + CW'(out_bit);
         cnt <= '0;
      end else if (start) cnt <= '0;
      else if (xfer) cnt <= cnt + CW'(out_bit);
`else
   assign alive_count = '0;
`endif
endmodule

// File: tb/tb_grid_scanner.sv
// tb_grid_scanner: randomized frame-level checks of grid_scanner against a snapshot/stream reference model.
module tb_grid_scanner;
   localparam int ROWS = 8, COLS = 8, N = ROWS * COLS, CW = $clog2(N + 1);
   logic qzt_clk = 1'b0, rst_n = 1'b0, gen_tick = 1'b0, out_ready = 1'b0, overrun_clr = 1'b0;
   logic [N-1:0] grid_state = '0;
   logic out_valid, out_bit, out_sof, out_eol, frame_done, overrun;
   logic [CW-1:0] alive_count;
   int asserts = 0, fails = 0;
   logic exp_ovr = 1'b0;
   logic [CW-1:0] exp_alive = '0;
   always #5 qzt_clk = ~qzt_clk;
   grid_scanner #(.ROWS(ROWS), .COLS(COLS)) dut (
      .qzt_clk(qzt_clk), .rst_n(rst_n), .gen_tick(gen_tick), .grid_state(grid_state),
      .out_ready(out_ready), .overrun_clr(overrun_clr), .out_valid(out_valid), .out_bit(out_bit),
      .out_sof(out_sof), .out_eol(out_eol), .frame_done(frame_done), .overrun(overrun),
      .alive_count(alive_count)
   );
   function automatic logic [CW-1:0] alive_of(input logic [N-1:0] g);
`ifdef GRID_SCANNER_POPCOUNT_EN
      return CW'($countones(g));
`else
      return '0;
`endif
   endfunction
   task automatic step();
      @(posedge qzt_clk);
      #1;
   endtask
   // Streams one frame; mode 0 ready=1, 1 ready toggles 1,0, 2 random ready.
   task automatic run_frame(input logic [N-1:0] g, input int mode, input bit started, input int chg_at,
                            input int tick_at, input bit tail_tick, input logic [N-1:0] g2, output int cycles);
      logic [N-1:0] snap;
      int k, cyc;
      bit ticked, dropped;
      snap = g;
      k = 0;
      cyc = 0;
      ticked = 0;
      cycles = 1;
      if (!started) begin
         grid_state = g;
         gen_tick = 1'b1;
         step();
         gen_tick = 1'b0;
      end
      while (k < N) begin
         asserts++;
         if ({out_valid, out_bit, out_sof, out_eol} !== {1'b1, snap[k], k == 0, k % COLS == COLS - 1}) begin
            fails++;
            $display("FAIL stream idx %0d: valid/bit/sof/eol got %b want %b", k,
                     {out_valid, out_bit, out_sof, out_eol}, {1'b1, snap[k], k == 0, k % COLS == COLS - 1});
         end
         asserts++;
         if (overrun !== exp_ovr) begin
            fails++;
            $display("FAIL overrun idx %0d: got %b want %b", k, overrun, exp_ovr);
         end
         if (cyc > 0) begin
            asserts++;
            if (frame_done !== 1'b0) begin
               fails++;
               $display("FAIL early frame_done idx %0d: got %b want 0", k, frame_done);
            end
         end
         out_ready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
         if (k == chg_at) grid_state = '1;
         dropped = (k == tick_at) && !ticked;
         if (dropped) begin
            ticked = 1;
            grid_state = ~snap;
         end
         gen_tick = dropped || (tail_tick && k == N - 1 && out_ready);
         if (tail_tick && k == N - 1 && out_ready) grid_state = g2;
         step();
         gen_tick = 1'b0;
         if (dropped) exp_ovr = 1'b1;
         if (out_ready) k++;
         cyc++;
         cycles++;
         if (cyc > 8 * N) begin
            fails++;
            $display("FAIL timeout: frame stuck at idx %0d after %0d cycles, want %0d transfers", k, cyc, N);
            return;
         end
      end
      exp_alive = alive_of(snap);
      asserts++;
      if ({frame_done, overrun, out_valid} !== {1'b1, exp_ovr, tail_tick}) begin
         fails++;
         $display("FAIL frame end done/ovr/valid: got %b want %b", {frame_done, overrun, out_valid},
                  {1'b1, exp_ovr, tail_tick});
      end
      asserts++;
      if (alive_count !== exp_alive) begin
         fails++;
         $display("FAIL alive_count: got %0d want %0d", alive_count, exp_alive);
      end
      if (!tail_tick) begin
         step();
         asserts++;
         if ({frame_done, out_valid, out_bit, out_sof, out_eol} !== 5'b0 || alive_count !== exp_alive) begin
            fails++;
            $display("FAIL post frame done/valid/bit/sof/eol %b alive %0d want 00000 alive %0d",
                     {frame_done, out_valid, out_bit, out_sof, out_eol}, alive_count, exp_alive);
         end
      end
   endtask
   task automatic test_reset();
      #3;
      asserts++;
      if ({out_valid, out_bit, out_sof, out_eol, frame_done, overrun} !== 6'b0 || alive_count !== '0) begin
         fails++;
         $display("FAIL reset outputs: got %b alive %0d want 000000 alive 0",
                  {out_valid, out_bit, out_sof, out_eol, frame_done, overrun}, alive_count);
      end
      @(negedge qzt_clk) rst_n = 1'b1;
      step();
      asserts++;
      if (out_valid !== 1'b0) begin
         fails++;
         $display("FAIL idle valid: got %b want 0", out_valid);
      end
   endtask
   task automatic test_basic();
      int c;
      run_frame(N'(7), 0, 0, -1, -1, 0, '0, c);
   endtask
   task automatic test_backpressure();
      int c;
      run_frame(N'(7), 1, 0, -1, -1, 0, '0, c);
      asserts++;
      if (c !== 2 * N) begin
         fails++;
         $display("FAIL backpressure length: got %0d cycles want %0d", c, 2 * N);
      end
   endtask
   task automatic test_snapshot();
      int c;
      run_frame(N'(7), 0, 0, 5, -1, 0, '0, c);
   endtask
   task automatic test_overrun();
      int c;
      logic [N-1:0] g;
      g = {$urandom, $urandom};
      run_frame(g, 2, 0, -1, 10, 0, '0, c);
      overrun_clr = 1'b1;
      step();
      overrun_clr = 1'b0;
      exp_ovr = 1'b0;
      asserts++;
      if (overrun !== 1'b0) begin
         fails++;
         $display("FAIL overrun clear: got %b want 0", overrun);
      end
      g = {$urandom, $urandom};
      grid_state = g;
      gen_tick = 1'b1;
      step();
      out_ready = 1'b0;
      overrun_clr = 1'b1;
      step();
      gen_tick = 1'b0;
      exp_ovr = 1'b1;
      asserts++;
      if (overrun !== 1'b1) begin
         fails++;
         $display("FAIL overrun set beats clear: got %b want 1", overrun);
      end
      step();
      overrun_clr = 1'b0;
      exp_ovr = 1'b0;
      asserts++;
      if (overrun !== 1'b0) begin
         fails++;
         $display("FAIL overrun clear in send: got %b want 0", overrun);
      end
      run_frame(g, 0, 1, -1, -1, 0, '0, c);
   endtask
   task automatic test_back_to_back();
      int c;
      logic [N-1:0] g1, g2;
      g1 = {$urandom, $urandom};
      g2 = {$urandom, $urandom};
      run_frame(g1, 2, 0, -1, -1, 1, g2, c);
      run_frame(g2, 0, 1, -1, -1, 0, '0, c);
   endtask
   task automatic test_reset_mid();
      int c;
      grid_state = {$urandom, $urandom};
      gen_tick = 1'b1;
      out_ready = 1'b1;
      step();
      gen_tick = 1'b0;
      repeat (20) step();
      #2 rst_n = 1'b0;
      exp_ovr = 1'b0;
      exp_alive = '0;
      #1;
      asserts++;
      if ({out_valid, out_bit, out_sof, out_eol, frame_done, overrun} !== 6'b0 || alive_count !== '0) begin
         fails++;
         $display("FAIL async reset outputs: got %b alive %0d want 000000 alive 0",
                  {out_valid, out_bit, out_sof, out_eol, frame_done, overrun}, alive_count);
      end
      step();
      step();
      @(negedge qzt_clk) rst_n = 1'b1;
      step();
      asserts++;
      if ({out_valid, frame_done} !== 2'b0) begin
         fails++;
         $display("FAIL after reset valid/done: got %b want 00", {out_valid, frame_done});
      end
      run_frame({$urandom, $urandom}, 0, 0, -1, -1, 0, '0, c);
   endtask
   task automatic test_random();
      int c;
      for (int i = 0; i < 4; i++) run_frame({$urandom, $urandom}, 2, 0, -1, -1, 0, '0, c);
   endtask
   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_snapshot();
      test_overrun();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end
endmodule
